timer_datapath: RTL and testbench
=================================

Name: timer_datapath

Overview:
- Countdown datapath for the egg timer; consumes the 3-bit STATE bus driven by the controller FSM and raw KEY[2] ("increment" key).
- Holds the mm:ss setting, counts down once per prescaled tick while running, and drives BCD digits to the 7-segment decoders.
- Returns a one-cycle EXPIRED pulse so the controller can leave RUN, and drives ALARM.

Parameters:
- TICK_DIV, 50000000, CLK cycles per countdown tick (1 s at 50 MHz); legal range ≥2.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RST_N  input  1  asynchronous active-low reset
- STATE  input  3  controller state: 000 RESET, 001 SET_SEC, 010 SET_MIN, 011 READY, 100 RUN, 101 DONE, 110/111 unused
- INC  input  1  level from KEY[2], already synchronised; high = pressed
- SEC_ONES  output  4  BCD seconds ones
- SEC_TENS  output  4  BCD seconds tens (0..5)
- MIN_ONES  output  4  BCD minutes ones
- MIN_TENS  output  4  BCD minutes tens (0..9)
- EXPIRED  output  1  one-cycle pulse to controller, time reached/is 00:00 in RUN
- ALARM  output  1  alarm drive, high in DONE

Behaviour:
- Reset (RST_N low, async): all digits 0, EXPIRED 0, ALARM 0, prescaler 0, INC edge register 0.
- INC edge: inc_pulse = INC & ~INC_q; INC_q registered every cycle regardless of STATE. Holding INC gives one increment only.
- All actions use the STATE value sampled in the same cycle; a STATE change coincident with inc_pulse applies the increment according to the old (sampled) STATE.
- RESET (000): digits cleared to 0 synchronously each cycle; prescaler 0; ALARM 0.
- SET_SEC (001): inc_pulse increments seconds in BCD, 00→…→59→00; minutes unaffected, no carry.
- SET_MIN (010): inc_pulse increments minutes in BCD, 00→…→99→00.
- READY (011): digits held; prescaler held at 0; inc_pulse ignored.
- RUN (100):
  - Prescaler counts 0..TICK_DIV-1, wraps; tick asserted in the cycle the count equals TICK_DIV-1.
  - On tick with time ≠ 00:00: decrement mm:ss in BCD (ones 0 borrows tens, seconds 00 borrows a minute → ss=59). If the result is 00:00, EXPIRED pulses in the following cycle.
  - If time is 00:00 in any RUN cycle and no EXPIRED was issued in the previous cycle: EXPIRED pulses next cycle (covers RUN entered with 00:00; no decrement, no underflow).
  - EXPIRED never high two consecutive cycles; it repeats only if the controller stays in RUN for another tick period.
  - inc_pulse ignored.
- DONE (101): digits frozen; ALARM registered high (asserted the cycle after STATE=101 is sampled), deasserted the cycle after STATE leaves 101; prescaler 0.
- Leaving RUN for any state resets the prescaler to 0; re-entering RUN starts a full tick period.
- 110/111: digits held, ALARM 0, EXPIRED 0, prescaler 0.
- Outputs are registers; no combinational path from STATE/INC to outputs.
- Reset asserted mid-countdown clears immediately; after release, the block behaves per STATE from the first clock edge.

Test Plan:
- TICK_DIV=4; RST_N low then high -> all digits 0, EXPIRED 0, ALARM 0.
- STATE=001, 3 INC presses (each held 10 cycles) -> SEC_TENS:SEC_ONES = 0:3. Then 60 presses total from 00 -> 00 (wrap at 59).
- STATE=010, 12 presses -> MIN_TENS:MIN_ONES = 1:2; 100 presses from 00 -> 00; seconds unchanged.
- Load 01:01, STATE=100 -> 00:60 never appears; after 4 cycles 01:00, after 8 cycles 00:59, after 61 ticks 00:00 with EXPIRED high exactly one cycle, one cycle after the digits show 00:00.
- STATE=100 with 00:00 loaded -> EXPIRED pulse within 2 cycles, digits stay 00:00; STATE=101 -> ALARM high next cycle; STATE=000 -> ALARM low next cycle.
- RST_N pulsed low mid-RUN at 00:30 -> digits 0 asynchronously, prescaler restarts; INC edge coincident with STATE 001→010 -> seconds (not minutes) increment.

Source files
------------

// File: rtl/timer_datapath.sv
// Egg-timer countdown datapath: holds the mm:ss setting in BCD, counts down on
// prescaled ticks while the controller is in RUN, and reports expiry/alarm.
module timer_datapath #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] STATE,
    input  logic       INC,
    output logic [3:0] SEC_ONES,
    output logic [3:0] SEC_TENS,
    output logic [3:0] MIN_ONES,
    output logic [3:0] MIN_TENS,
    output logic       EXPIRED,
    output logic       ALARM
);

    localparam logic [2:0] ST_RESET   = 3'b000;
    localparam logic [2:0] ST_SET_SEC = 3'b001;
    localparam logic [2:0] ST_SET_MIN = 3'b010;
    localparam logic [2:0] ST_READY   = 3'b011;
    localparam logic [2:0] ST_RUN     = 3'b100;
    localparam logic [2:0] ST_DONE    = 3'b101;

    localparam int             CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  TERM = CW'(TICK_DIV - 1);

    // Time word layout: {min_tens, min_ones, sec_tens, sec_ones}
    logic [15:0]   r_time;
    logic [CW-1:0] r_presc;
    logic          r_inc_q;
    logic          r_expired;
    logic          r_exp_seen;
    logic          r_alarm;

    logic [15:0]   w_time_next;
    logic [CW-1:0] w_presc_next;
    logic          w_expired_next;
    logic          w_exp_seen_next;
    logic          w_inc_pulse;
    logic          w_tick;
    logic          w_zero;

    // Two-digit BCD increment; tens wraps to 0 after tens_max:9.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [3:0] tens_max);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == tens_max) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[7:4] = v[7:4];
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // mm:ss BCD decrement with borrow chain; caller guarantees t != 00:00.
    function automatic logic [15:0] mmss_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (t[7:4] != 4'd0) begin
                r[7:4] = t[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (t[11:8] != 4'd0) begin
                    r[11:8] = t[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign w_inc_pulse = INC & ~r_inc_q;
    assign w_tick      = (r_presc == TERM);
    assign w_zero      = (r_time == 16'h0000);

    always_comb begin
        w_time_next     = r_time;
        w_presc_next    = '0;
        w_expired_next  = 1'b0;
        w_exp_seen_next = 1'b0;
        case (STATE)
            ST_RESET: begin
                w_time_next = 16'h0000;
            end
            ST_SET_SEC: begin
                if (w_inc_pulse) begin
                    w_time_next[7:0] = bcd2_inc(r_time[7:0], 4'd5);
                end
            end
            ST_SET_MIN: begin
                if (w_inc_pulse) begin
                    w_time_next[15:8] = bcd2_inc(r_time[15:8], 4'd9);
                end
            end
            ST_RUN: begin
                w_presc_next = w_tick ? '0 : r_presc + CW'(1);
                if (w_tick && !w_zero) begin
                    w_time_next = mmss_dec(r_time);
                end
                // One expiry report per tick period while the time sits at 00:00
                w_expired_next  = w_zero & ~r_exp_seen;
                w_exp_seen_next = w_expired_next | (r_exp_seen & ~w_tick);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_time     <= 16'h0000;
            r_presc    <= '0;
            r_inc_q    <= 1'b0;
            r_expired  <= 1'b0;
            r_exp_seen <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_time     <= w_time_next;
            r_presc    <= w_presc_next;
            r_inc_q    <= INC;
            r_expired  <= w_expired_next;
            r_exp_seen <= w_exp_seen_next;
            r_alarm    <= (STATE == ST_DONE);
        end
    end

    assign SEC_ONES = r_time[3:0];
    assign SEC_TENS = r_time[7:4];
    assign MIN_ONES = r_time[11:8];
    assign MIN_TENS = r_time[15:12];
    assign EXPIRED  = r_expired;
    assign ALARM    = r_alarm;

    logic w_unused_ready;
    assign w_unused_ready = (ST_READY == 3'b011);

endmodule

// File: tb/tb_timer_datapath.sv
// Bench for timer_datapath: directed vector table, hand-written corner sequences
// and randomized stimulus checked against a seconds-based reference model.
module tb_timer_datapath;

    localparam int TD = 4;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic [2:0] STATE = 3'd0;
    logic       INC   = 1'b0;
    logic [3:0] SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS;
    logic       EXPIRED, ALARM;

    timer_datapath #(.TICK_DIV(TD)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .STATE    (STATE),
        .INC      (INC),
        .SEC_ONES (SEC_ONES),
        .SEC_TENS (SEC_TENS),
        .MIN_ONES (MIN_ONES),
        .MIN_TENS (MIN_TENS),
        .EXPIRED  (EXPIRED),
        .ALARM    (ALARM)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time kept as minutes/seconds integers
    int m_mm, m_ss, m_cnt;
    bit m_inc_q, m_exp, m_seen, m_alarm;

    typedef struct {
        logic [2:0] st;
        logic       inc;
        int         mmss;
        logic       exp;
        logic       alarm;
    } vec_t;

    vec_t vecs[14];

    function automatic void check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic int shown_mmss();
        return int'(MIN_TENS) * 1000 + int'(MIN_ONES) * 100 + int'(SEC_TENS) * 10 + int'(SEC_ONES);
    endfunction

    function automatic void model_reset();
        m_mm = 0; m_ss = 0; m_cnt = 0;
        m_inc_q = 0; m_exp = 0; m_seen = 0; m_alarm = 0;
    endfunction

    function automatic void model_clock(input logic [2:0] st, input logic inc);
        bit pulse, tick, nexp;
        int total;
        pulse   = inc && !m_inc_q;
        m_inc_q = inc;
        nexp    = 0;
        total   = m_mm * 60 + m_ss;
        if (st == 3'd4) begin
            tick = (m_cnt == TD - 1);
            nexp = (total == 0) && !m_seen;
            if (tick && total != 0) total = total - 1;
            m_mm   = total / 60;
            m_ss   = total % 60;
            m_cnt  = tick ? 0 : m_cnt + 1;
            m_seen = nexp || (m_seen && !tick);
        end else begin
            m_cnt  = 0;
            m_seen = 0;
            if (st == 3'd0) begin
                m_mm = 0; m_ss = 0;
            end else if (st == 3'd1 && pulse) begin
                m_ss = (m_ss + 1) % 60;
            end else if (st == 3'd2 && pulse) begin
                m_mm = (m_mm + 1) % 100;
            end
        end
        m_exp   = nexp;
        m_alarm = (st == 3'd5);
    endfunction

    function automatic void compare_model();
        bit valid;
        valid = (SEC_ONES <= 9) && (SEC_TENS <= 5) && (MIN_ONES <= 9) && (MIN_TENS <= 9);
        check("bcd_valid", int'(valid), 1);
        check("mdl_mmss", shown_mmss(), (m_mm / 10) * 1000 + (m_mm % 10) * 100 + m_ss);
        check("mdl_expired", int'(EXPIRED), int'(m_exp));
        check("mdl_alarm", int'(ALARM), int'(m_alarm));
    endfunction

    task automatic step(input logic [2:0] st, input logic inc);
        STATE = st;
        INC   = inc;
        @(posedge CLK);
        model_clock(st, inc);
        #1;
        compare_model();
    endtask

    task automatic press(input logic [2:0] st, input int hold);
        repeat (hold) step(st, 1'b1);
        step(st, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("async_clear_mmss", shown_mmss(), 0);
        check("async_clear_exp", int'(EXPIRED), 0);
        check("async_clear_alarm", int'(ALARM), 0);
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        int r, hold;
        logic [2:0] st;
        bit seen_exp;

        vecs[0]  = '{3'd1, 1'b1,  1, 1'b0, 1'b0};
        vecs[1]  = '{3'd1, 1'b1,  1, 1'b0, 1'b0};
        vecs[2]  = '{3'd1, 1'b0,  1, 1'b0, 1'b0};
        vecs[3]  = '{3'd1, 1'b1,  2, 1'b0, 1'b0};
        vecs[4]  = '{3'd2, 1'b0,  2, 1'b0, 1'b0};
        vecs[5]  = '{3'd2, 1'b1, 102, 1'b0, 1'b0};
        vecs[6]  = '{3'd3, 1'b0, 102, 1'b0, 1'b0};
        vecs[7]  = '{3'd3, 1'b1, 102, 1'b0, 1'b0};
        vecs[8]  = '{3'd5, 1'b0, 102, 1'b0, 1'b1};
        vecs[9]  = '{3'd5, 1'b1, 102, 1'b0, 1'b1};
        vecs[10] = '{3'd0, 1'b0,  0, 1'b0, 1'b0};
        vecs[11] = '{3'd6, 1'b1,  0, 1'b0, 1'b0};
        vecs[12] = '{3'd4, 1'b0,  0, 1'b1, 1'b0};
        vecs[13] = '{3'd4, 1'b0,  0, 1'b0, 1'b0};

        // Reset state while RST_N is held low from time zero
        model_reset();
        #2;
        check("reset_mmss", shown_mmss(), 0);
        check("reset_expired", int'(EXPIRED), 0);
        check("reset_alarm", int'(ALARM), 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].st, vecs[i].inc);
            check("vec_mmss", shown_mmss(), vecs[i].mmss);
            check("vec_expired", int'(EXPIRED), int'(vecs[i].exp));
            check("vec_alarm", int'(ALARM), int'(vecs[i].alarm));
            $display("vec %0d: state=%0d inc=%0b -> %0d%0d:%0d%0d exp=%0b alarm=%0b",
                     i, vecs[i].st, vecs[i].inc, MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES, EXPIRED, ALARM);
        end

        // Seconds setting and wrap at 59
        step(3'd0, 1'b0);
        repeat (3) press(3'd1, 10);
        check("sec_three", int'(SEC_TENS) * 10 + int'(SEC_ONES), 3);
        repeat (57) press(3'd1, 1);
        check("sec_wrap", int'(SEC_TENS) * 10 + int'(SEC_ONES), 0);
        $display("seq sec: 60 presses -> %0d%0d", SEC_TENS, SEC_ONES);

        // Minutes setting and wrap at 99
        step(3'd1, 1'b0);
        repeat (12) press(3'd2, 1);
        check("min_twelve", int'(MIN_TENS) * 10 + int'(MIN_ONES), 12);
        repeat (88) press(3'd2, 1);
        check("min_wrap", int'(MIN_TENS) * 10 + int'(MIN_ONES), 0);
        check("min_sec_untouched", int'(SEC_TENS) * 10 + int'(SEC_ONES), 0);
        $display("seq min: 100 presses -> %0d%0d", MIN_TENS, MIN_ONES);

        // Countdown from 01:01
        step(3'd0, 1'b0);
        press(3'd1, 1);
        press(3'd2, 1);
        check("load_0101", shown_mmss(), 101);
        for (int c = 1; c <= 250; c++) begin
            step(3'd4, 1'b0);
            if (c == 4)   check("run_0100", shown_mmss(), 100);
            if (c == 8)   check("run_0059", shown_mmss(), 59);
            if (c == 244) begin
                check("run_zero", shown_mmss(), 0);
                check("run_zero_noexp", int'(EXPIRED), 0);
            end
            if (c == 245) check("run_exp_pulse", int'(EXPIRED), 1);
            if (c == 246) check("run_exp_single", int'(EXPIRED), 0);
        end
        $display("seq countdown: 01:01 -> %0d%0d:%0d%0d", MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES);

        // RUN entered with 00:00, then DONE / alarm
        step(3'd0, 1'b0);
        step(3'd4, 1'b0);
        seen_exp = EXPIRED;
        step(3'd4, 1'b0);
        seen_exp = seen_exp | EXPIRED;
        check("zero_run_exp", int'(seen_exp), 1);
        check("zero_run_mmss", shown_mmss(), 0);
        step(3'd5, 1'b0);
        check("done_alarm_on", int'(ALARM), 1);
        step(3'd0, 1'b0);
        check("reset_alarm_off", int'(ALARM), 0);
        $display("seq zero-run: expired seen=%0b", seen_exp);

        // Async reset mid-RUN at 00:30, then prescaler restarts a full period
        repeat (30) press(3'd1, 1);
        check("load_0030", shown_mmss(), 30);
        repeat (2) step(3'd4, 1'b0);
        do_reset();
        press(3'd1, 1);
        press(3'd1, 1);
        for (int c = 1; c <= 4; c++) begin
            step(3'd4, 1'b0);
            if (c == 3) check("presc_restart_hold", shown_mmss(), 2);
            if (c == 4) check("presc_restart_tick", shown_mmss(), 1);
        end
        $display("seq reset-mid-run: %0d%0d:%0d%0d", MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES);

        // INC edge sampled with SET_SEC while STATE moves to SET_MIN
        step(3'd0, 1'b0);
        step(3'd1, 1'b0);
        step(3'd1, 1'b1);
        step(3'd2, 1'b1);
        check("coincident_sec", int'(SEC_TENS) * 10 + int'(SEC_ONES), 1);
        check("coincident_min", int'(MIN_TENS) * 10 + int'(MIN_ONES), 0);
        $display("seq coincident: %0d%0d:%0d%0d", MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES);

        // Randomized run against the model
        hold = 0;
        st   = 3'd0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                r    = $urandom_range(0, 11);
                st   = (r < 8) ? 3'(r) : 3'd4;
                hold = $urandom_range(1, 40);
            end
            hold--;
            if ($urandom_range(0, 599) == 0) do_reset();
            step(st, 1'($urandom_range(0, 1)));
        end
        $display("seq random: 3000 steps done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
